// File: rtl/cdcm_tx_pkg.sv
// Shared types and constant helpers for the CDCM transmit waveform generator:
// symbol pattern builders, sequencer state encoding and offset-table entries.
package cdcm_tx_pkg;

   localparam int MAX_DEV_W = 16;

   typedef logic [MAX_DEV_W-1:0] sym_t;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      SCAN = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Pattern of dev_w bits whose top 'ones' bits are set; rising edge is always the MSB.
   function automatic sym_t ones_msb(int dev_w, int ones);
      sym_t p;
      p = '0;
      for (int i = 0; i < MAX_DEV_W; i++) begin
         if (i < dev_w && i >= dev_w - ones) p[i] = 1'b1;
      end
      return p;
   endfunction

   function automatic sym_t idle_pattern(int dev_w);
      return ones_msb(dev_w, dev_w / 2);
   endfunction

   function automatic sym_t one_pattern(int dev_w, int mod_depth);
      return ones_msb(dev_w, dev_w / 2 + mod_depth);
   endfunction

   function automatic sym_t zero_pattern(int dev_w, int mod_depth);
      return ones_msb(dev_w, dev_w / 2 - mod_depth);
   endfunction

   // Callers keep the low table-width bits, which yields the value modulo 2^width.
   function automatic logic [31:0] offset_entry(int base, int idx);
      return 32'(base + idx);
   endfunction

   function automatic int min_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdcm_tx_waveform_gen_if.sv
// Data/status bundle between the CDCM TX data source (master) and the
// waveform generator (slave).
interface cdcm_tx_waveform_gen_if
   import cdcm_tx_pkg::*;
#(
   parameter int kSysW         = 1,
   parameter int kDevW         = 8,
   parameter int kNumTaps      = 8,
   parameter int kWidthScanTdc = 8
);
   localparam int TAP_W = min_width(kNumTaps);

   logic [kSysW-1:0]                  dataIn;
   logic                              validIn;
   logic                              readyOut;
   logic                              forceIdle;
   logic [kSysW*kDevW-1:0]            dOutToSerdes;
   logic [TAP_W-1:0]                  scanTap;
   logic [kNumTaps*kWidthScanTdc-1:0] offsetTable;
   logic                              scanFinished;

   modport master (
      output dataIn, validIn, forceIdle,
      input  readyOut, dOutToSerdes, scanTap, offsetTable, scanFinished
   );

   modport slave (
      input  dataIn, validIn, forceIdle,
      output readyOut, dOutToSerdes, scanTap, offsetTable, scanFinished
   );

endinterface

// File: rtl/cdcm_symbol_enc.sv
// One CDCM symbol: maps (data bit, idle request) to its kDevW-bit waveform.
module cdcm_symbol_enc
   import cdcm_tx_pkg::*;
#(
   parameter int kDevW     = 8,
   parameter int kModDepth = 1
) (
   input  logic             bit_i,
   input  logic             idle_i,
   output logic [kDevW-1:0] sym_o
);
   localparam logic [kDevW-1:0] IDLE_SYM = kDevW'(idle_pattern(kDevW));
   localparam logic [kDevW-1:0] ONE_SYM  = kDevW'(one_pattern(kDevW, kModDepth));
   localparam logic [kDevW-1:0] ZERO_SYM = kDevW'(zero_pattern(kDevW, kModDepth));

   assign sym_o = idle_i ? IDLE_SYM : (bit_i ? ONE_SYM : ZERO_SYM);

endmodule

// File: rtl/cdcm_tx_waveform_gen.sv
// CDCM TX parallel waveform generator: post-reset idle/scan sequencer followed
// by per-symbol encoding of dataIn into the OSERDES input word.
module cdcm_tx_waveform_gen
   import cdcm_tx_pkg::*;
#(
   parameter int kSysW         = 1,
   parameter int kDevW         = 8,
   parameter int kModDepth     = 1,
   parameter int kNumTaps      = 8,
   parameter int kWidthScanTdc = 8,
   parameter int kOffsetBase   = -5,
   parameter int kInitLen      = 64,
   parameter int kScanLen      = 16
) (
   input logic                   clkDivIn,
   input logic                   ioReset,
   cdcm_tx_waveform_gen_if.slave bus
);
   localparam int WORD_W  = kSysW * kDevW;
   localparam int TABLE_W = kNumTaps * kWidthScanTdc;
   localparam int TAP_W   = min_width(kNumTaps);
   localparam int CNT_W   = min_width((kInitLen > kScanLen) ? kInitLen : kScanLen);

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(kInitLen - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(kScanLen - 1);
   localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(kNumTaps - 1);
   localparam logic [kDevW-1:0] IDLE_SYM  = kDevW'(idle_pattern(kDevW));

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TAP_W-1:0]   tap_q;
   logic               fin_q;
   logic [WORD_W-1:0]  dout_q;
   logic [WORD_W-1:0]  dout_d;
   logic [WORD_W-1:0]  idle_word;
   logic [TABLE_W-1:0] table_init;
   logic [TABLE_W-1:0] table_q;
   logic               sym_idle;

   // forceIdle outranks validIn, and nothing is encoded before the sequencer reaches RUN.
   assign sym_idle  = (state_q != RUN) || bus.forceIdle || !bus.validIn;
   assign idle_word = {kSysW{IDLE_SYM}};

   for (genvar j = 0; j < kSysW; j++) begin : g_sym
      cdcm_symbol_enc #(
         .kDevW    (kDevW),
         .kModDepth(kModDepth)
      ) u_enc (
         .bit_i (bus.dataIn[kSysW-1-j]),
         .idle_i(sym_idle),
         .sym_o (dout_d[(kSysW-j)*kDevW-1 -: kDevW])
      );
   end

   for (genvar i = 0; i < kNumTaps; i++) begin : g_tab
      localparam logic [31:0] ENTRY = offset_entry(kOffsetBase, i);
      assign table_init[i*kWidthScanTdc +: kWidthScanTdc] = ENTRY[kWidthScanTdc-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from pre-edge values regardless of statement order.
   always_ff @(posedge clkDivIn) begin
      if (ioReset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         tap_q   <= '0;
         fin_q   <= 1'b0;
         dout_q  <= idle_word;
         // NOTE: the offset table only loads under reset and holds afterwards,
         // so it needs no enable path of its own.
         table_q <= table_init;
      end else begin
         dout_q <= dout_d;
         unique case (state_q)
            INIT: begin
               if (cnt_q == INIT_LAST) begin
                  state_q <= SCAN;
                  cnt_q   <= '0;
                  tap_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            SCAN: begin
               if (cnt_q == SCAN_LAST) begin
                  cnt_q <= '0;
                  if (tap_q == TAP_LAST) begin
                     state_q <= RUN;
                     fin_q   <= 1'b1;
                  end else begin
                     tap_q <= tap_q + TAP_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               fin_q <= 1'b1;
            end
            default: begin
               state_q <= INIT;
               cnt_q   <= '0;
               tap_q   <= '0;
               fin_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dOutToSerdes = dout_q;
   assign bus.scanTap      = tap_q;
   assign bus.scanFinished = fin_q;
   assign bus.readyOut     = fin_q;
   assign bus.offsetTable  = table_q;

endmodule

// File: tb/tb_cdcm_tx_waveform_gen.sv
// Directed bench: default configuration (A) and a 2-symbol, 10-bit, depth-2,
// 4-tap, zero-base configuration (B) with short idle/scan lengths.
module tb_cdcm_tx_waveform_gen;

   localparam int A_INIT   = 64;
   localparam int A_SCAN   = 16;
   localparam int A_TAPS   = 8;
   localparam int A_RUN_AT = A_INIT + A_TAPS * A_SCAN;
   localparam int B_INIT   = 4;
   localparam int B_SCAN   = 3;
   localparam int B_TAPS   = 4;
   localparam int B_RUN_AT = B_INIT + B_TAPS * B_SCAN;

   localparam logic [63:0] A_IDLE  = 64'hF0;
   localparam logic [63:0] A_ONE   = 64'hF8;
   localparam logic [63:0] A_ZERO  = 64'hE0;
   localparam logic [63:0] A_TABLE = 64'h0201_00FF_FEFD_FCFB;
   localparam logic [63:0] B_IDLE  = 64'hF83E0;
   localparam logic [63:0] B_TABLE = 64'h0302_0100;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   cdcm_tx_waveform_gen_if #(
      .kSysW(1), .kDevW(8), .kNumTaps(A_TAPS), .kWidthScanTdc(8)
   ) bus_a ();

   cdcm_tx_waveform_gen_if #(
      .kSysW(2), .kDevW(10), .kNumTaps(B_TAPS), .kWidthScanTdc(8)
   ) bus_b ();

   cdcm_tx_waveform_gen #(
      .kSysW(1), .kDevW(8), .kModDepth(1), .kNumTaps(A_TAPS), .kWidthScanTdc(8),
      .kOffsetBase(-5), .kInitLen(A_INIT), .kScanLen(A_SCAN)
   ) u_dut_a (
      .clkDivIn(clk),
      .ioReset (rst_a),
      .bus     (bus_a)
   );

   cdcm_tx_waveform_gen #(
      .kSysW(2), .kDevW(10), .kModDepth(2), .kNumTaps(B_TAPS), .kWidthScanTdc(8),
      .kOffsetBase(0), .kInitLen(B_INIT), .kScanLen(B_SCAN)
   ) u_dut_b (
      .clkDivIn(clk),
      .ioReset (rst_b),
      .bus     (bus_b)
   );

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Steps n cycles after reset release, comparing each cycle against the sequencer timeline.
   task automatic walk(int n, bit with_b);
      int exp_tap;
      for (int e = 1; e <= n; e++) begin
         step(1);
         exp_tap = (e < A_INIT) ? 0 : (e - A_INIT) / A_SCAN;
         if (exp_tap > A_TAPS - 1) exp_tap = A_TAPS - 1;
         check($sformatf("a_dout@%0d", e), 64'(bus_a.dOutToSerdes), A_IDLE);
         check($sformatf("a_tap@%0d", e), 64'(bus_a.scanTap), 64'(exp_tap));
         check($sformatf("a_fin@%0d", e), 64'(bus_a.scanFinished), 64'(e >= A_RUN_AT));
         check($sformatf("a_ready@%0d", e), 64'(bus_a.readyOut), 64'(e >= A_RUN_AT));
         if (with_b) begin
            exp_tap = (e < B_INIT) ? 0 : (e - B_INIT) / B_SCAN;
            if (exp_tap > B_TAPS - 1) exp_tap = B_TAPS - 1;
            check($sformatf("b_dout@%0d", e), 64'(bus_b.dOutToSerdes), B_IDLE);
            check($sformatf("b_tap@%0d", e), 64'(bus_b.scanTap), 64'(exp_tap));
            check($sformatf("b_fin@%0d", e), 64'(bus_b.scanFinished), 64'(e >= B_RUN_AT));
         end
      end
   endtask

   task automatic check_a_reset(string tag);
      check({tag, "_dout"}, 64'(bus_a.dOutToSerdes), A_IDLE);
      check({tag, "_tap"}, 64'(bus_a.scanTap), 64'd0);
      check({tag, "_fin"}, 64'(bus_a.scanFinished), 64'd0);
      check({tag, "_ready"}, 64'(bus_a.readyOut), 64'd0);
      check({tag, "_table"}, 64'(bus_a.offsetTable), A_TABLE);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.dataIn    = 1'b1;
      bus_a.validIn   = 1'b1;
      bus_a.forceIdle = 1'b0;
      bus_b.dataIn    = 2'b00;
      bus_b.validIn   = 1'b0;
      bus_b.forceIdle = 1'b0;

      step(3);
      check_a_reset("por_a");
      check("por_b_dout", 64'(bus_b.dOutToSerdes), B_IDLE);
      check("por_b_fin", 64'(bus_b.scanFinished), 64'd0);
      check("por_b_table", 64'(bus_b.offsetTable), B_TABLE);

      // Valid data offered throughout INIT/SCAN must not reach the output.
      rst_a = 1'b0;
      rst_b = 1'b0;
      walk(A_RUN_AT, 1'b1);

      bus_a.dataIn = 1'b1;
      step(1);
      check("run_one", 64'(bus_a.dOutToSerdes), A_ONE);
      bus_a.dataIn = 1'b0;
      step(1);
      check("run_zero", 64'(bus_a.dOutToSerdes), A_ZERO);
      bus_a.dataIn = 1'b1;
      step(1);
      check("run_one_again", 64'(bus_a.dOutToSerdes), A_ONE);
      bus_a.validIn = 1'b0;
      step(1);
      check("run_novalid", 64'(bus_a.dOutToSerdes), A_IDLE);

      bus_a.validIn   = 1'b1;
      bus_a.forceIdle = 1'b1;
      step(1);
      check("force_idle", 64'(bus_a.dOutToSerdes), A_IDLE);
      check("force_ready", 64'(bus_a.readyOut), 64'd1);
      bus_a.forceIdle = 1'b0;
      step(1);
      check("force_release", 64'(bus_a.dOutToSerdes), A_ONE);
      check("run_tap_hold", 64'(bus_a.scanTap), 64'd7);
      check("run_table", 64'(bus_a.offsetTable), A_TABLE);

      bus_b.validIn = 1'b1;
      bus_b.dataIn  = 2'b10;
      step(1);
      check("b_data_10", 64'(bus_b.dOutToSerdes), 64'hFE380);
      bus_b.dataIn = 2'b01;
      step(1);
      check("b_data_01", 64'(bus_b.dOutToSerdes), 64'hE03F8);
      bus_b.forceIdle = 1'b1;
      step(1);
      check("b_force_idle", 64'(bus_b.dOutToSerdes), B_IDLE);
      check("b_tap_hold", 64'(bus_b.scanTap), 64'd3);
      check("b_table", 64'(bus_b.offsetTable), B_TABLE);

      // Mid-RUN reset: output was 0xF8 going in, must be idle right after.
      rst_a = 1'b1;
      step(1);
      check_a_reset("run_rst");
      rst_a = 1'b0;
      walk(A_INIT + 3 * A_SCAN + 5, 1'b0);

      // Mid-SCAN reset while on tap 3.
      rst_a = 1'b1;
      step(1);
      check_a_reset("scan_rst");
      rst_a = 1'b0;
      walk(A_RUN_AT, 1'b0);
      step(1);
      check("rerun_one", 64'(bus_a.dOutToSerdes), A_ONE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
